// File: rtl/encode_8b10b_nlane_if.sv
// Word-level bus between the framer side and the multi-lane 8b/10b encoder.
// The master drives the byte word and RD preload; the slave returns the encoded symbols.
interface encode_8b10b_nlane_if #(
  parameter int NLANE = 2
);
  logic                  valid_in;
  logic [8*NLANE-1:0]    data_in;
  logic [NLANE-1:0]      k_en;
  logic                  rd_load;
  logic                  rd_load_val;
  logic [10*NLANE-1:0]   data_out;
  logic                  valid;
  logic [NLANE-1:0]      k_err;
  logic                  rd;

  modport master (
    output valid_in, data_in, k_en, rd_load, rd_load_val,
    input  data_out, valid, k_err, rd
  );

  modport slave (
    input  valid_in, data_in, k_en, rd_load, rd_load_val,
    output data_out, valid, k_err, rd
  );
endinterface

// File: rtl/encode_8b10b_nlane.sv
// Multi-lane 8b/10b encoder: NLANE bytes per clock, running disparity chained lane 0 -> NLANE-1
// and carried to the next word, with RD preload and per-lane illegal-K flagging.
module encode_8b10b_nlane #(
  parameter int NLANE   = 2,
  parameter bit RD_INIT = 1'b0
) (
  input logic                clk,
  input logic                rst,
  encode_8b10b_nlane_if.slave bus
);

  logic [10*NLANE-1:0] data_q;
  logic [10*NLANE-1:0] code_next;
  logic [NLANE-1:0]    kerr_q;
  logic [NLANE-1:0]    kerr_next;
  logic                valid_q;
  logic                rd_q;
  logic                rd_end;
  logic                rd_run;
  logic [11:0]         sym;

  // Returns {k_err, ending RD, abcdei, fghj}. Tables hold the RD- form; the RD+ form is the
  // complement for unbalanced codes plus the balanced-but-paired D.7 (6b) and D.x.3 (4b).
  function automatic logic [11:0] encode_symbol(input logic [7:0] b, input logic k,
                                                input logic rd_in);
    logic [4:0] x;
    logic [2:0] y;
    logic       legal;
    logic       k28;
    logic       alt;
    logic       flip6;
    logic       flip4;
    logic       rd_mid;
    logic       rd_out;
    logic [5:0] six;
    logic [3:0] four;
    x     = b[4:0];
    y     = b[7:5];
    legal = (x == 5'd28) ||
            ((y == 3'd7) && (x == 5'd23 || x == 5'd27 || x == 5'd29 || x == 5'd30));
    k28   = k && legal && (x == 5'd28);
    six   = '0;
    case (x)
      5'd0:  six = 6'b100111;
      5'd1:  six = 6'b011101;
      5'd2:  six = 6'b101101;
      5'd3:  six = 6'b110001;
      5'd4:  six = 6'b110101;
      5'd5:  six = 6'b101001;
      5'd6:  six = 6'b011001;
      5'd7:  six = 6'b111000;
      5'd8:  six = 6'b111001;
      5'd9:  six = 6'b100101;
      5'd10: six = 6'b010101;
      5'd11: six = 6'b110100;
      5'd12: six = 6'b001101;
      5'd13: six = 6'b101100;
      5'd14: six = 6'b011100;
      5'd15: six = 6'b010111;
      5'd16: six = 6'b011011;
      5'd17: six = 6'b100011;
      5'd18: six = 6'b010011;
      5'd19: six = 6'b110010;
      5'd20: six = 6'b001011;
      5'd21: six = 6'b101010;
      5'd22: six = 6'b011010;
      5'd23: six = 6'b111010;
      5'd24: six = 6'b110011;
      5'd25: six = 6'b100110;
      5'd26: six = 6'b010110;
      5'd27: six = 6'b110110;
      5'd28: six = 6'b001110;
      5'd29: six = 6'b101110;
      5'd30: six = 6'b011110;
      5'd31: six = 6'b101011;
      default: six = 6'b000000;
    endcase
    if (k28) six = 6'b001111;
    flip6  = ($countones(six) != 3) || (x == 5'd7);
    rd_mid = ($countones(six) == 3) ? rd_in : ~rd_in;
    if (rd_in && flip6) six = ~six;

    // A7 avoids a run of five equal bits across the 6b/4b boundary; Kx.7 always uses it.
    alt = (y == 3'd7) &&
          ((k && legal && !k28) ||
           (!rd_mid && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
           (rd_mid && (x == 5'd11 || x == 5'd13 || x == 5'd14)));
    four  = '0;
    flip4 = 1'b1;
    if (k28) begin
      case (y)
        3'd0: four = 4'b1011;
        3'd1: four = 4'b0110;
        3'd2: four = 4'b1010;
        3'd3: four = 4'b1100;
        3'd4: four = 4'b1101;
        3'd5: four = 4'b0101;
        3'd6: four = 4'b1001;
        3'd7: four = 4'b0111;
        default: four = 4'b0000;
      endcase
    end else if (alt) begin
      four = 4'b0111;
    end else begin
      case (y)
        3'd0: four = 4'b1011;
        3'd1: four = 4'b1001;
        3'd2: four = 4'b0101;
        3'd3: four = 4'b1100;
        3'd4: four = 4'b1101;
        3'd5: four = 4'b1010;
        3'd6: four = 4'b0110;
        3'd7: four = 4'b1110;
        default: four = 4'b0000;
      endcase
      flip4 = ($countones(four) != 2) || (y == 3'd3);
    end
    if (rd_mid && flip4) four = ~four;
    rd_out = ($countones(four) == 2) ? rd_mid : ~rd_mid;
    return {k && !legal, rd_out, six, four};
  endfunction

  always_comb begin
    code_next = '0;
    kerr_next = '0;
    sym       = '0;
    rd_run    = bus.rd_load ? bus.rd_load_val : rd_q;
    for (int n = 0; n < NLANE; n++) begin
      sym                   = encode_symbol(bus.data_in[8*n +: 8], bus.k_en[n], rd_run);
      code_next[10*n +: 10] = sym[9:0];
      kerr_next[n]          = sym[11];
      rd_run                = sym[10];
    end
    rd_end = rd_run;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      kerr_q  <= '0;
      valid_q <= 1'b0;
      rd_q    <= RD_INIT;
    end else begin
      valid_q <= bus.valid_in;
      if (bus.valid_in) begin
        data_q <= code_next;
        kerr_q <= kerr_next;
        rd_q   <= rd_end;
      end else if (bus.rd_load) begin
        rd_q <= bus.rd_load_val;
      end
    end
  end

  assign bus.data_out = data_q;
  assign bus.k_err    = kerr_q;
  assign bus.valid    = valid_q;
  assign bus.rd       = rd_q;

endmodule

// File: tb/tb_encode_8b10b_nlane.sv
// Scoreboard bench for encode_8b10b_nlane (NLANE=2): table-driven reference encoder and decoder,
// directed known-code checks, exhaustive byte/K sweeps from both RDs, mid-sweep reset, random words.
module tb_encode_8b10b_nlane;
  localparam int NLANE   = 2;
  localparam bit RD_INIT = 1'b0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  encode_8b10b_nlane_if #(.NLANE(NLANE)) bus ();
  encode_8b10b_nlane #(.NLANE(NLANE), .RD_INIT(RD_INIT)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [10*NLANE-1:0] data_out;
    logic [NLANE-1:0]    k_err;
    logic                valid;
    logic                rd;
  } exp_t;

  exp_t sb[$];
  int   assert_count = 0;
  int   fail_count   = 0;

  logic                m_rd;
  logic [10*NLANE-1:0] m_dout;
  logic [NLANE-1:0]    m_kerr;

  // Both table columns written out in full: index by the RD in force at that sub-block.
  logic [5:0] t6n [32] = '{6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001,
                           6'b011001, 6'b111000, 6'b111001, 6'b100101, 6'b010101, 6'b110100,
                           6'b001101, 6'b101100, 6'b011100, 6'b010111, 6'b011011, 6'b100011,
                           6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
                           6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110,
                           6'b011110, 6'b101011};
  logic [5:0] t6p [32] = '{6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001,
                           6'b011001, 6'b000111, 6'b000110, 6'b100101, 6'b010101, 6'b110100,
                           6'b001101, 6'b101100, 6'b011100, 6'b101000, 6'b100100, 6'b100011,
                           6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b000101,
                           6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001,
                           6'b100001, 6'b010100};
  logic [3:0] t4n [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
  logic [3:0] t4p [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b0001};
  logic [3:0] k4n [8] = '{4'b1011, 4'b0110, 4'b1010, 4'b1100, 4'b1101, 4'b0101, 4'b1001, 4'b0111};
  logic [3:0] k4p [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b1000};
  logic [7:0] kcodes [12] = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC,
                              8'hF7, 8'hFB, 8'hFD, 8'hFE};

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assert_count++;
    if (got !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic disp_after(input int ones, input int half, input logic rd_in);
    if (ones > half) return 1'b1;
    if (ones < half) return 1'b0;
    return rd_in;
  endfunction

  function automatic void model_symbol(input logic [7:0] b, input logic k, input logic rd_in,
                                       output logic [9:0] code, output logic rd_out,
                                       output logic kerr);
    logic [4:0] x;
    logic [2:0] y;
    logic       legal;
    logic       k28;
    logic       alt;
    logic       rd_mid;
    logic [5:0] six;
    logic [3:0] four;
    x      = b[4:0];
    y      = b[7:5];
    legal  = (x == 5'd28) || (y == 3'd7 && (x == 5'd23 || x == 5'd27 || x == 5'd29 || x == 5'd30));
    kerr   = k && !legal;
    k28    = k && legal && (x == 5'd28);
    six    = k28 ? (rd_in ? 6'b110000 : 6'b001111) : (rd_in ? t6p[x] : t6n[x]);
    rd_mid = disp_after($countones(six), 3, rd_in);
    alt    = (y == 3'd7) && ((k && legal) ||
             (!rd_mid && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
             (rd_mid && (x == 5'd11 || x == 5'd13 || x == 5'd14)));
    if (k28)      four = rd_mid ? k4p[y] : k4n[y];
    else if (alt) four = rd_mid ? 4'b1000 : 4'b0111;
    else          four = rd_mid ? t4p[y] : t4n[y];
    rd_out = disp_after($countones(four), 2, rd_mid);
    code   = {six, four};
  endfunction

  // Returns {err, k, HGF, EDCBA}.
  function automatic logic [9:0] decode_symbol(input logic [9:0] c);
    logic [5:0] six;
    logic [3:0] four;
    logic       f6;
    logic       f4;
    logic       k;
    logic [4:0] x;
    logic [2:0] y;
    six = c[9:4]; four = c[3:0]; f6 = 1'b0; f4 = 1'b0; k = 1'b0; x = '0; y = '0;
    if (six == 6'b001111 || six == 6'b110000) begin
      k = 1'b1; x = 5'd28; f6 = 1'b1;
      for (int i = 0; i < 8; i++)
        if ((six == 6'b001111) ? (four == k4p[i]) : (four == k4n[i])) begin
          y = 3'(i); f4 = 1'b1;
        end
    end else begin
      for (int i = 0; i < 32; i++)
        if (six == t6n[i] || six == t6p[i]) begin x = 5'(i); f6 = 1'b1; end
      if (four == 4'b0111 || four == 4'b1000) begin
        y = 3'd7; f4 = 1'b1;
        k = (x == 5'd23 || x == 5'd27 || x == 5'd29 || x == 5'd30);
      end else begin
        for (int i = 0; i < 8; i++)
          if (four == t4n[i] || four == t4p[i]) begin y = 3'(i); f4 = 1'b1; end
      end
    end
    return {!(f6 && f4), k, y, x};
  endfunction

  function automatic void model_word(input logic vi, input logic [8*NLANE-1:0] d,
                                     input logic [NLANE-1:0] k, input logic rl, input logic rlv,
                                     output exp_t e);
    logic       r;
    logic       ro;
    logic       ke;
    logic [9:0] c;
    if (vi) begin
      r = rl ? rlv : m_rd;
      for (int n = 0; n < NLANE; n++) begin
        model_symbol(d[8*n +: 8], k[n], r, c, ro, ke);
        m_dout[10*n +: 10] = c;
        m_kerr[n]          = ke;
        r                  = ro;
      end
      m_rd = r;
    end else if (rl) begin
      m_rd = rlv;
    end
    e.data_out = m_dout;
    e.k_err    = m_kerr;
    e.valid    = vi;
    e.rd       = m_rd;
  endfunction

  task automatic applyStimulus(input logic vi, input logic [8*NLANE-1:0] d,
                               input logic [NLANE-1:0] k, input logic rl, input logic rlv);
    exp_t e;
    bus.valid_in    = vi;
    bus.data_in     = d;
    bus.k_en        = k;
    bus.rd_load     = rl;
    bus.rd_load_val = rlv;
    model_word(vi, d, k, rl, rlv, e);
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checkOutput("sb_empty", 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      checkOutput("data_out", 32'(bus.data_out), 32'(e.data_out));
      checkOutput("k_err", 32'(bus.k_err), 32'(e.k_err));
      checkOutput("valid", 32'(bus.valid), 32'(e.valid));
      checkOutput("rd", 32'(bus.rd), 32'(e.rd));
    end
  endtask

  task automatic checkDecode(input logic [8*NLANE-1:0] d, input logic [NLANE-1:0] k);
    for (int n = 0; n < NLANE; n++)
      checkOutput("decode", 32'(decode_symbol(bus.data_out[10*n +: 10])),
                  32'({1'b0, k[n], d[8*n +: 8]}));
  endtask

  task automatic resetMid();
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_valid", 32'(bus.valid), 32'd0);
    checkOutput("rst_rd", 32'(bus.rd), 32'(RD_INIT));
    checkOutput("rst_data", 32'(bus.data_out), 32'd0);
    checkOutput("rst_kerr", 32'(bus.k_err), 32'd0);
    m_rd   = RD_INIT;
    m_dout = '0;
    m_kerr = '0;
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    logic [8*NLANE-1:0] d;
    logic [NLANE-1:0]   k;
    bus.valid_in = 1'b0; bus.data_in = '0; bus.k_en = '0; bus.rd_load = 1'b0; bus.rd_load_val = 1'b0;
    m_rd = RD_INIT; m_dout = '0; m_kerr = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_data", 32'(bus.data_out), 32'd0);
    checkOutput("reset_valid", 32'(bus.valid), 32'd0);
    checkOutput("reset_kerr", 32'(bus.k_err), 32'd0);
    checkOutput("reset_rd", 32'(bus.rd), 32'(RD_INIT));
    rst = 1'b0;

    applyStimulus(1'b1, {8'hB5, 8'hBC}, 2'b01, 1'b0, 1'b0);
    checkOutput("k28_5_rdm", 32'(bus.data_out[9:0]), 32'h0FA);
    checkOutput("d21_5_l1", 32'(bus.data_out[19:10]), 32'h2AA);
    checkOutput("rd_after_k", 32'(bus.rd), 32'd1);
    applyStimulus(1'b1, {8'hB5, 8'hBC}, 2'b01, 1'b0, 1'b0);
    checkOutput("k28_5_rdp", 32'(bus.data_out[9:0]), 32'h305);
    checkOutput("rd_back", 32'(bus.rd), 32'd0);
    applyStimulus(1'b1, {8'hBC, 8'hBC}, 2'b11, 1'b0, 1'b0);
    checkOutput("k2_l0", 32'(bus.data_out[9:0]), 32'h0FA);
    checkOutput("k2_l1", 32'(bus.data_out[19:10]), 32'h305);
    applyStimulus(1'b0, {8'hBC, 8'hBC}, 2'b11, 1'b0, 1'b0);
    checkOutput("hold_valid", 32'(bus.valid), 32'd0);
    checkOutput("hold_data", 32'(bus.data_out), 32'({10'h305, 10'h0FA}));

    applyStimulus(1'b1, 16'h0000, 2'b00, 1'b0, 1'b0);
    checkOutput("d0_0_rdm", 32'(bus.data_out), 32'({10'h274, 10'h274}));
    checkOutput("d0_0_rd", 32'(bus.rd), 32'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 16'hB5B5, 2'b00, 1'b0, 1'b0);
      checkOutput("d21_5", 32'(bus.data_out), 32'({10'h2AA, 10'h2AA}));
    end
    applyStimulus(1'b1, {8'hB5, 8'h00}, 2'b00, 1'b1, 1'b1);
    checkOutput("d0_0_rdp", 32'(bus.data_out[9:0]), 32'h18B);
    checkOutput("load_rd1", 32'(bus.rd), 32'd1);
    applyStimulus(1'b0, 16'h0000, 2'b00, 1'b1, 1'b0);
    checkOutput("load_idle_rd", 32'(bus.rd), 32'd0);

    applyStimulus(1'b1, {8'hB5, 8'h00}, 2'b01, 1'b1, 1'b0);
    checkOutput("illegal_k_err", 32'(bus.k_err), 32'd1);
    checkOutput("illegal_k_code", 32'(bus.data_out[9:0]), 32'h274);
    applyStimulus(1'b1, {8'hB5, 8'hF7}, 2'b01, 1'b1, 1'b0);
    checkOutput("k23_7_rdm", 32'(bus.data_out[9:0]), 32'h3A8);
    checkOutput("k23_7_err", 32'(bus.k_err), 32'd0);
    applyStimulus(1'b1, {8'hB5, 8'hF7}, 2'b01, 1'b1, 1'b1);
    checkOutput("k23_7_rdp", 32'(bus.data_out[9:0]), 32'h057);

    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 256; i++) begin
        if (r == 1 && i == 128) resetMid();
        d = {8'(255 - i), 8'(i)};
        applyStimulus(1'b1, d, 2'b00, 1'b1, r[0]);
        checkDecode(d, 2'b00);
      end
      for (int j = 0; j < 12; j++) begin
        d = {kcodes[(j + 5) % 12], kcodes[j]};
        applyStimulus(1'b1, d, 2'b11, 1'b1, r[0]);
        checkDecode(d, 2'b11);
      end
    end

    for (int i = 0; i < 60; i++) begin
      d = 16'($urandom);
      k = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) d[7:0] = kcodes[$urandom_range(0, 11)];
      applyStimulus($urandom_range(0, 4) != 0, d, k, $urandom_range(0, 3) == 0,
                    1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL timeout: got no finish, expected finish before 500000");
    $fatal(1, "[TB] timeout");
  end
endmodule
